// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults for the register-file write path. The same values are used
// by register_file, decode and the benches.
//   NREQ_DEF  - number of write requesters
//   AW_DEF    - register address width
//   DW_DEF    - register data width
//   REG_COUNT - number of architectural registers
package regfile_write_arbiter_pkg;
  localparam int NREQ_DEF  = 2;
  localparam int AW_DEF    = 2;
  localparam int DW_DEF    = 4;
  localparam int REG_COUNT = 2 ** AW_DEF;

  // Width needed to hold an index in 0..n-1. Never returns zero, so a
  // pointer always has at least one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Round-robin arbiter with a one-hot combinational grant.
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset; last_grant goes to N-1, so
//           requester 0 has highest priority
//   req   - request vector
//   grant - one-hot grant, zero when req is zero
// The search starts just above last_grant and wraps. last_grant moves only
// when a grant is issued, so idle cycles leave the priority order unchanged.
module rr_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int N = NREQ_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = ptr_w(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N - 1);

  logic [PW-1:0] last_grant;
  logic [PW-1:0] grant_idx;
  logic [N-1:0]  hi_mask;
  logic [N-1:0]  req_hi;
  logic [N-1:0]  pick_src;

  // Requesters above last_grant come first. If none of them is asking, the
  // search wraps to the whole vector. This avoids any modulo arithmetic,
  // so it also works for N=3.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < N; i++) hi_mask[i] = (PW'(i) > last_grant);
  end

  assign req_hi   = req & hi_mask;
  assign pick_src = (|req_hi) ? req_hi : req;

  // Pick the lowest set bit of pick_src. The loop runs downward, so the last
  // hit it records is the lowest one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last_grant <= LAST_IDX;
    else if (|req) last_grant <= grant_idx;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Owns the single register_file write port (C/D/E). It shares that port
// between NREQ writers and keeps a per-register pending scoreboard so that
// decode can stall reads of registers that still have a write outstanding.
//   clk, rst            - clock; asynchronous active-high reset
//   req/req_addr/req_data - flattened requester i at [i*AW +: AW]/[i*DW +: DW]
//   ack                 - combinational one-hot grant; the transfer happens
//                         at the edge where req&ack
//   wr_addr/wr_data/wr_en - registered outputs to register_file C/D/E
//   claim_valid/claim_addr - decode marks a destination register as pending
//   rd_addr_a/rd_addr_b - decode read addresses
//   pending             - registered scoreboard, one bit per register
//   stall               - combinational, not bypassed
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = AW_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [AW-1:0]        wr_addr,
  output logic [DW-1:0]        wr_data,
  output logic                 wr_en,
  input  logic                 claim_valid,
  input  logic [AW-1:0]        claim_addr,
  input  logic [AW-1:0]        rd_addr_a,
  input  logic [AW-1:0]        rd_addr_b,
  output logic [(2**AW)-1:0]   pending,
  output logic                 stall
);
  localparam int RC = 2 ** AW;

  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic [RC-1:0] pending_nxt;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .grant (ack)
  );

  // ack is one-hot, so OR-ing the masked fields gives the granted payload.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // When there is no grant, addr and data hold their last values and only
  // the enable drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= |ack;
      if (|ack) begin
        wr_addr <= sel_addr;
        wr_data <= sel_data;
      end
    end
  end

  // Set has priority over clear. If a register is claimed on the same edge
  // that its previous write commits, the new producer keeps it pending.
  always_comb begin
    pending_nxt = pending;
    for (int r = 0; r < RC; r++) begin
      if (claim_valid && claim_addr == AW'(r))  pending_nxt[r] = 1'b1;
      else if (wr_en && wr_addr == AW'(r))      pending_nxt[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign stall = pending[rd_addr_a] | pending[rd_addr_b];
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (NREQ=2, AW=2, DW=4).
// It includes a small register_file model, so that a committed write can be
// read back from the model.
module tb_regfile_write_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic [1:0] ack;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_en;
  logic       claim_valid;
  logic [1:0] claim_addr;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [3:0] pending;
  logic       stall;

  logic [3:0] rf [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.NREQ(2), .AW(2), .DW(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .ack         (ack),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .claim_valid (claim_valid),
    .claim_addr  (claim_addr),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .pending     (pending),
    .stall       (stall)
  );

  // register_file model: it commits at the edge after the write is issued.
  always @(posedge clk) if (!rst && wr_en) rf[wr_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_ack [4];
    logic [3:0] exp_dat [4];
    exp_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_dat = '{4'h3, 4'hC, 4'h3, 4'hC};
    for (int i = 0; i < 4; i++) rf[i] = 4'h0;
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    #2;
    chk("rst_wr_en", wr_en, 1'b0);
    chk("rst_wr_addr", wr_addr, 2'b00);
    chk("rst_wr_data", wr_data, 4'h0);
    chk("rst_pending", pending, 4'b0000);
    req = 2'b11; #1;
    chk("rst_ack_comb", ack, 2'b01);
    req = 2'b00; #1;
    chk("rst_ack_none", ack, 2'b00);
    tick(); tick();
    rst = 1'b0;

    // Single writer: requester 1 writes 1010 to register 2.
    req = 2'b10; req_addr = {2'b10, 2'b00}; req_data = {4'b1010, 4'h0}; #1;
    chk("single_ack", ack, 2'b10);
    tick();
    chk("single_wr_en", wr_en, 1'b1);
    chk("single_wr_addr", wr_addr, 2'b10);
    chk("single_wr_data", wr_data, 4'b1010);
    req = 2'b00; #1;
    chk("single_ack_drop", ack, 2'b00);
    tick();
    chk("single_wr_en_low", wr_en, 1'b0);
    chk("single_addr_hold", wr_addr, 2'b10);
    chk("single_rf_read", rf[2], 4'b1010);

    // Contention: both requesters hold their requests for 4 cycles.
    req = 2'b11; req_addr = {2'b01, 2'b01}; req_data = {4'hC, 4'h3};
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("cont_ack", ack, exp_ack[i]);
      tick();
      chk("cont_wr_en", wr_en, 1'b1);
      chk("cont_wr_data", wr_data, exp_dat[i]);
    end
    req = 2'b00;

    // Idle: no requests for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_wr_en", wr_en, 1'b0);
      chk("idle_wr_addr", wr_addr, 2'b01);
      chk("idle_wr_data", wr_data, 4'hC);
    end
    req = 2'b11; #1;
    chk("idle_ptr_kept", ack, 2'b01);
    req = 2'b00; #1;

    // Scoreboard: claim register 3, stall its readers, then clear it with a write.
    claim_valid = 1'b1; claim_addr = 2'b11;
    tick();
    claim_valid = 1'b0;
    chk("sb_claim", pending, 4'b1000);
    rd_addr_a = 2'b00; rd_addr_b = 2'b11; #1;
    chk("sb_stall_b", stall, 1'b1);
    rd_addr_a = 2'b11; rd_addr_b = 2'b00; #1;
    chk("sb_stall_a", stall, 1'b1);
    rd_addr_a = 2'b01; #1;
    chk("sb_no_stall", stall, 1'b0);
    rd_addr_a = 2'b11;
    req = 2'b01; req_addr = {2'b00, 2'b11}; req_data = {4'h0, 4'h5}; #1;
    chk("sb_ack", ack, 2'b01);
    tick();
    req = 2'b00;
    chk("sb_issue_wr_en", wr_en, 1'b1);
    chk("sb_still_pending", pending, 4'b1000);
    chk("sb_still_stall", stall, 1'b1);
    tick();
    chk("sb_cleared", pending, 4'b0000);
    chk("sb_stall_gone", stall, 1'b0);
    chk("sb_rf_read", rf[3], 4'h5);

    // Claim and commit to register 1 on the same edge: the set wins.
    req = 2'b10; req_addr = {2'b01, 2'b00}; req_data = {4'h7, 4'h0}; #1;
    chk("col_ack", ack, 2'b10);
    tick();
    req = 2'b00;
    chk("col_wr_addr", wr_addr, 2'b01);
    claim_valid = 1'b1; claim_addr = 2'b01;
    tick();
    claim_valid = 1'b0;
    chk("col_set_wins", pending, 4'b0010);
    tick();
    chk("col_hold", pending, 4'b0010);

    // Reset asserted mid-cycle while wr_en=1 and pending=0110.
    claim_valid = 1'b1; claim_addr = 2'b10;
    req = 2'b01; req_addr = {2'b00, 2'b00}; req_data = {4'h0, 4'h9};
    tick();
    claim_valid = 1'b0; req = 2'b00;
    chk("mid_pre_wr_en", wr_en, 1'b1);
    chk("mid_pre_pending", pending, 4'b0110);
    #2 rst = 1'b1;
    #1;
    chk("mid_wr_en", wr_en, 1'b0);
    chk("mid_wr_addr", wr_addr, 2'b00);
    chk("mid_wr_data", wr_data, 4'h0);
    chk("mid_pending", pending, 4'b0000);
    tick();
    chk("mid_write_lost", rf[0], 4'h0);
    rst = 1'b0;
    req = 2'b11; req_data = {4'hC, 4'h9}; #1;
    chk("post_rst_ack", ack, 2'b01);
    tick();
    req = 2'b00;
    chk("post_rst_wr_en", wr_en, 1'b1);
    chk("post_rst_wr_data", wr_data, 4'h9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
